switch_debouncer: RTL and testbench

//   Conditions the raw DIP-switch inputs before the LED logic and seven-segment decoder see them.

---
 rtl/switch_debouncer.sv | 93 +++++++++
 tb/tb_switch_debouncer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Switch conditioner: 2-flop synchronizer, then a per-bit stability counter.
// Outputs debounced levels, rise/fall pulses, and a startup valid flag.

module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+3)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  input  logic valid,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(DEBOUNCE_CYCLES-1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == clean) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        // Level is accepted even before valid; only the pulses are suppressed.
        clean <= sync;
        cnt   <= '0;
        rise  <= valid & sync;
        fall  <= valid & ~sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+3)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_raw,
  output logic [WIDTH-1:0] s_clean,
  output logic [WIDTH-1:0] s_rise,
  output logic [WIDTH-1:0] s_fall,
  output logic             valid
);
  localparam logic [CNT_W-1:0] ST_MAX = CNT_W'(DEBOUNCE_CYCLES+2);
  localparam logic [CNT_W-1:0] ST_PRE = CNT_W'(DEBOUNCE_CYCLES+1);

  logic [1:0][WIDTH-1:0] sync_pipe;
  logic [CNT_W-1:0]      st_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[0], s_raw};
  end

  // Startup window: valid rises on the edge the counter reaches DEBOUNCE_CYCLES+2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_cnt <= '0;
      valid  <= 1'b0;
    end else begin
      if (st_cnt != ST_MAX) st_cnt <= st_cnt + 1'b1;
      if (st_cnt == ST_PRE) valid  <= 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .sync   (sync_pipe[1][i]),
      .valid  (valid),
      .clean  (s_clean[i]),
      .rise   (s_rise[i]),
      .fall   (s_fall[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_switch_debouncer;
  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] s_raw, s_clean, s_rise, s_fall;
  logic         valid;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .s_raw  (s_raw),
    .s_clean(s_clean),
    .s_rise (s_rise),
    .s_fall (s_fall),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] raw;
    int           n;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         vld;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] c, input logic [W-1:0] r,
                         input logic [W-1:0] f, input logic v);
    chk({name, ".clean"}, 32'(s_clean), 32'(c));
    chk({name, ".rise"},  32'(s_rise),  32'(r));
    chk({name, ".fall"},  32'(s_fall),  32'(f));
    chk({name, ".valid"}, 32'(valid),   32'(v));
    chk({name, ".excl"},  32'(s_rise & s_fall), 32'(0));
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Level sequence: power-up at 1010, clean 0->1 on bit 0, drop all, raise all
    tbl[0]  = '{"pwr_wait",  4'b1010, 9,  4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{"pwr_done",  4'b1010, 1,  4'b1010, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{"pwr_hold",  4'b1010, 1,  4'b1010, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{"b0_wait",   4'b1011, 9,  4'b1010, 4'b0000, 4'b0000, 1'b1};
    tbl[4]  = '{"b0_rise",   4'b1011, 1,  4'b1011, 4'b0001, 4'b0000, 1'b1};
    tbl[5]  = '{"b0_after",  4'b1011, 1,  4'b1011, 4'b0000, 4'b0000, 1'b1};
    tbl[6]  = '{"all_fall",  4'b0000, 10, 4'b0000, 4'b0000, 4'b1011, 1'b1};
    tbl[7]  = '{"fall_end",  4'b0000, 1,  4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[8]  = '{"all_wait",  4'b1111, 9,  4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{"all_rise",  4'b1111, 1,  4'b1111, 4'b1111, 4'b0000, 1'b1};
    tbl[10] = '{"rise_end",  4'b1111, 1,  4'b1111, 4'b0000, 4'b0000, 1'b1};

    reset_n = 1'b0;
    s_raw   = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      adv(1);
      chk_out("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Every step starts at a negedge so the next posedge is the sampling edge.
    foreach (tbl[i]) begin
      s_raw = tbl[i].raw;
      adv(tbl[i].n);
      chk_out(tbl[i].name, tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].vld);
      @(negedge clk);
    end

    // Bit 1 bounces in runs of 3: never reaches the window
    for (int c = 0; c < 15; c++) begin
      s_raw = {2'b11, ((c / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1};
      adv(1);
      chk_out("bounce", 4'b1111, 4'b0000, 4'b0000, 1'b1);
      @(negedge clk);
    end
    s_raw = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      adv(1);
      chk_out("bounce_settle", 4'b1111, 4'b0000, 4'b0000, 1'b1);
      @(negedge clk);
    end

    // Bit 2 glitch of 7 cycles: rejected
    s_raw = 4'b1011;
    for (int c = 0; c < 7; c++) begin
      adv(1);
      chk_out("glitch7", 4'b1111, 4'b0000, 4'b0000, 1'b1);
      @(negedge clk);
    end
    s_raw = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      adv(1);
      chk_out("glitch7_after", 4'b1111, 4'b0000, 4'b0000, 1'b1);
      @(negedge clk);
    end

    // Bit 2 held low 8 cycles: accepted, then the return to 1 is accepted too
    s_raw = 4'b1011;
    adv(8);
    chk_out("hold8_wait", 4'b1111, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    s_raw = 4'b1111;
    adv(1);
    chk_out("hold8_e9", 4'b1111, 4'b0000, 4'b0000, 1'b1);
    adv(1);
    chk_out("hold8_fall", 4'b1011, 4'b0000, 4'b0100, 1'b1);
    adv(1);
    chk_out("hold8_fall_end", 4'b1011, 4'b0000, 4'b0000, 1'b1);
    adv(6);
    chk_out("back_wait", 4'b1011, 4'b0000, 4'b0000, 1'b1);
    adv(1);
    chk_out("back_rise", 4'b1111, 4'b0100, 4'b0000, 1'b1);
    @(negedge clk);

    // Reset while bits 1 and 3 are pending (cnt=5); new window after release
    s_raw = 4'b0101;
    adv(7);
    chk_out("pend_cnt5", 4'b1111, 4'b0000, 4'b0000, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_out("mid_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    adv(9);
    chk_out("rel_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    adv(1);
    chk_out("rel_done", 4'b0101, 4'b0000, 4'b0000, 1'b1);
    adv(1);
    chk_out("rel_hold", 4'b0101, 4'b0000, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
